// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction-fetch front end. Owns the fetch PC, reads two
//            consecutive words per cycle from program memory and buffers
//            them in an in-order prefetch queue. The queue head goes to
//            decode through a valid/ready handshake. A redirect flushes the
//            queue and restarts fetch at a new PC.
// Options  : FETCH_STALL_CNT_EN - adds a saturating fetch-starve counter
//            (stall_cnt) with a synchronous clear (stall_cnt_clr).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int unsigned               ADDR_WIDTH  = 11,
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter int unsigned               QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr0,
    output logic [ADDR_WIDTH-1:0] imem_addr1,
    input  logic [DATA_WIDTH-1:0] imem_data0,
    input  logic [DATA_WIDTH-1:0] imem_data1,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    input  logic                  stall_cnt_clr
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Architectural state
    logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    // Queue storage: instruction word and its byte address per entry
    logic [DATA_WIDTH-1:0] data_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] epc_q  [QUEUE_DEPTH];

    logic [CNT_W-1:0]      w_free;
    logic                  w_push0;
    logic                  w_push1;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_num_push;
    logic [PTR_W-1:0]      w_wr_ptr1;
    logic [ADDR_WIDTH-1:0] w_redirect_tgt;
    logic                  w_unused;

    // Low address bits of a redirect are don't-care; the target is word aligned
    assign w_unused       = ^redirect_pc[1:0];
    assign w_redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign imem_addr0 = pc_q;
    assign imem_addr1 = pc_q + ADDR_WIDTH'(4);

    // Head is hidden during a redirect so decode never consumes flushed data
    assign inst_valid = (count_q != '0) && !redirect_valid;
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = epc_q[rd_ptr_q];

    // Free space is judged before any same-cycle pop, so a pop never
    // enables an extra push in the same cycle
    assign w_free     = CNT_W'(QUEUE_DEPTH) - count_q;
    assign w_pop      = inst_valid && inst_ready;
    assign w_push0    = !redirect_valid && (w_free != '0);
    assign w_push1    = !redirect_valid && (w_free >= CNT_W'(2));
    assign w_num_push = CNT_W'(w_push0) + CNT_W'(w_push1);
    assign w_wr_ptr1  = wr_ptr_q + PTR_W'(1);

    // Next-state for PC, pointers and occupancy; redirect overrides all
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = w_redirect_tgt;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push1) begin
                pc_d = pc_q + ADDR_WIDTH'(8);
            end else if (w_push0) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(w_num_push);
            rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
            count_d  = count_q + w_num_push - CNT_W'(w_pop);
        end
    end

    // State register for PC, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage write: word0 at the tail, word1 right behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                data_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else begin
            if (w_push0) begin
                data_q[wr_ptr_q] <= imem_data0;
                epc_q[wr_ptr_q]  <= imem_addr0;
            end
            if (w_push1) begin
                data_q[w_wr_ptr1] <= imem_data1;
                epc_q[w_wr_ptr1]  <= imem_addr1;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Count cycles decode is starved outside a redirect; clear wins, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (!inst_valid && !redirect_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue. A behavioural program
//            memory answers the DUT's read ports; a queue-based reference
//            model predicts every delivered instruction. Directed scenarios
//            (streaming, back-pressure, redirect while full, address wrap,
//            redirect with ready, mid-run reset) precede a random phase.
// Options  : FETCH_STALL_CNT_EN - also checks stall_cnt / stall_cnt_clr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int unsigned     AW    = 11;
    localparam int unsigned     DW    = 32;
    localparam int unsigned     DEPTH = 4;
    localparam logic [AW-1:0]   RPC   = '0;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] imem_addr0, imem_addr1;
    logic [DW-1:0] imem_data0, imem_data1;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]   stall_cnt;
    logic          stall_cnt_clr;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];     // expected queue contents, head first
    logic [AW-1:0] mpc;       // expected fetch PC
    logic [31:0]   mstall;    // expected stall counter

    fetch_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .QUEUE_DEPTH(DEPTH),
        .RESET_PC   (RPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr0    (imem_addr0),
        .imem_addr1    (imem_addr1),
        .imem_data0    (imem_data0),
        .imem_data1    (imem_data1),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .stall_cnt_clr (stall_cnt_clr)
`endif
    );

    // Program memory contents: a tag plus the byte address
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    assign imem_data0 = mem(imem_addr0);
    assign imem_data1 = mem(imem_addr1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model: compare at the falling edge, then advance
    // the model to what the next rising edge must produce
    always @(negedge clk) begin
        logic ev;
        int   free;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            mpc    = RPC;
            mstall = '0;
            check("rst_valid", 64'(inst_valid), 64'd0);
            check("rst_data",  64'(inst_data),  64'd0);
            check("rst_pc",    64'(inst_pc),    64'd0);
            check("rst_addr0", 64'(imem_addr0), 64'(RPC));
            check("rst_addr1", 64'(imem_addr1), 64'(AW'(RPC + AW'(4))));
`ifdef FETCH_STALL_CNT_EN
            check("rst_stall", 64'(stall_cnt),  64'd0);
`endif
        end else begin
            ev = (mq.size() != 0) && !redirect_valid;
            check("valid", 64'(inst_valid), 64'(ev));
            check("addr0", 64'(imem_addr0), 64'(mpc));
            check("addr1", 64'(imem_addr1), 64'(AW'(mpc + AW'(4))));
            if (ev) begin
                check("head_pc",   64'(inst_pc),   64'(mq[0].pc));
                check("head_data", 64'(inst_data), 64'(mq[0].data));
            end
`ifdef FETCH_STALL_CNT_EN
            check("stall_cnt", 64'(stall_cnt), 64'(mstall));
            if (stall_cnt_clr)
                mstall = '0;
            else if (!ev && !redirect_valid && mstall != 32'hFFFF_FFFF)
                mstall = mstall + 1;
`endif
            if (redirect_valid) begin
                mq.delete();
                mpc = {redirect_pc[AW-1:2], 2'b00};
            end else begin
                free = int'(DEPTH) - mq.size();
                if (ev && inst_ready)
                    void'(mq.pop_front());
                for (int k = 0; k < 2; k++) begin
                    if (free > k) begin
                        e.pc   = mpc;
                        e.data = mem(mpc);
                        mq.push_back(e);
                        mpc = mpc + AW'(4);
                    end
                end
            end
        end
    end

    // Advance to just after the next rising edge, then apply new inputs
    task automatic drive(input logic rdy, input logic rv, input logic [AW-1:0] rpc, input logic clr);
        @(posedge clk);
        #1;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
`ifdef FETCH_STALL_CNT_EN
        stall_cnt_clr  = clr;
`else
        if (clr) begin end
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
`ifdef FETCH_STALL_CNT_EN
        stall_cnt_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;

        // Streaming with ready held high
        repeat (10) drive(1'b1, 1'b0, '0, 1'b0);

        // Back-pressure from an empty queue, then release
        drive(1'b0, 1'b1, 11'h000, 1'b0);
        repeat (6) drive(1'b0, 1'b0, '0, 1'b0);
        repeat (8) drive(1'b1, 1'b0, '0, 1'b0);

        // Fill the queue, redirect to an unaligned target while full
        repeat (3) drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 11'h103, 1'b0);
        repeat (6) drive(1'b1, 1'b0, '0, 1'b0);

        // Redirect with ready high and a valid head: no consumption
        drive(1'b1, 1'b1, 11'h200, 1'b0);
        repeat (4) drive(1'b1, 1'b0, '0, 1'b0);

        // Address wrap from the top of the space
        drive(1'b1, 1'b1, 11'h7F8, 1'b0);
        repeat (8) drive(1'b1, 1'b0, '0, 1'b0);

        // Counter clear pulse
        drive(1'b1, 1'b0, '0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, '0, 1'b0);

        // Reset in the middle of activity
        drive(1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        repeat (2) drive(1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        repeat (6) drive(1'b1, 1'b0, '0, 1'b0);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) != 0,
                  ($urandom % 16) == 0,
                  AW'($urandom),
                  ($urandom % 32) == 0);
        end
        drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
